iob_regfile_arb: RTL and testbench
==================================

IOB_REGFILE_ARB -- requirements
Module: iob_regfile_arb

Interface
REQ-001 Parameter DATA_W, default 32, entry data width in bits.
REQ-002 Parameter ADDR_W, default 3, entry address width; the file SHALL hold 2**ADDR_W entries.
REQ-003 Parameter RST_VAL, default 0, value of every entry after reset or clear, truncated/zero-extended to DATA_W.
REQ-004 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 arst_i  input  1  asynchronous active-high reset.
REQ-006 rst_i  input  1  synchronous active-high reset, same effect as arst_i.
REQ-007 clr_i  input  1  one-cycle request to sequentially clear all entries.
REQ-008 busy_o  output  1  high while the clear sequence runs.
REQ-009 req_valid_i  input  2  per-requester request valid, bit k = requester k.
REQ-010 req_we_i  input  2  per-requester write enable (1 = write, 0 = read).
REQ-011 req_addr_i  input  2*ADDR_W  per-requester entry address, requester k in slice k.
REQ-012 req_wdata_i  input  2*DATA_W  per-requester write data.
REQ-013 req_ready_o  output  2  per-requester accept, one-hot or zero.
REQ-014 rsp_valid_o  output  2  per-requester read-response strobe.
REQ-015 rsp_data_o  output  2*DATA_W  per-requester read data.

Function
REQ-016 States SHALL be IDLE and CLEAR; reset state IDLE.
REQ-017 In IDLE with clr_i=0 and rst_i=0, grant: only one valid -> that requester; both valid -> requester not granted at last transfer; none valid -> no grant.
REQ-018 req_ready_o SHALL be combinational from grant; zero in CLEAR, when clr_i=1, or when rst_i=1.
REQ-019 A transfer occurs when req_valid_i[k] and req_ready_o[k] are both high; at most one transfer per cycle.
REQ-020 Last-grant register SHALL update only on a transfer; reset value selects requester 0 as winner of the first contention.
REQ-021 Write transfer: addressed entry SHALL take req_wdata_i slice at the same edge; no response generated.
REQ-022 Read transfer: rsp_valid_o[k] SHALL pulse high exactly one cycle after acceptance, with rsp_data_o slice k holding the entry value present at acceptance.
REQ-023 rsp_data_o slice SHALL hold its last value while rsp_valid_o bit is low.
REQ-024 clr_i=1 in IDLE SHALL enter CLEAR at next edge, overriding any same-cycle request (no transfer).
REQ-025 CLEAR SHALL write RST_VAL to entry 0,1,...,2**ADDR_W-1, one per cycle, then return to IDLE; busy_o high for exactly 2**ADDR_W cycles.
REQ-026 clr_i asserted during CLEAR SHALL be ignored (no restart, no extension).
REQ-027 A read accepted in the cycle before clr_i SHALL still produce its response.

Reset
REQ-028 arst_i (async) and rst_i (sync) SHALL set: all entries RST_VAL, state IDLE, clear counter 0, last-grant to requester 1, rsp_valid_o 0, rsp_data_o 0, busy_o 0.
REQ-029 rst_i asserted mid-CLEAR SHALL abort to IDLE with all entries RST_VAL.
REQ-030 No transfer SHALL occur in a cycle with rst_i=1.

Structure
REQ-031 Shared package SHALL hold state encoding (IDLE, CLEAR) and requester count constant 2.
REQ-032 Sub-module iob_rr_arb2 SHALL implement the 2-way round-robin grant and last-grant register; storage, FSM and response logic stay in the top.

Verification
REQ-033 After arst_i pulse: read requester 0 addr 5 -> rsp_valid_o[0] one cycle later, data RST_VAL (0).
REQ-034 Requester 0 writes 0xDEADBEEF to addr 3, then requester 1 reads addr 3 -> rsp_data_o slice 1 = 0xDEADBEEF.
REQ-035 Both requesters valid reading for 4 consecutive cycles -> grants 0,1,0,1; each rsp_valid_o bit pulses twice.
REQ-036 Fill all 8 entries with 0x11*index, pulse clr_i with req_valid_i=2'b11 -> no ready that cycle, busy_o high 8 cycles, then all reads return 0.
REQ-037 rst_i asserted in 3rd CLEAR cycle -> busy_o low next cycle, all entries 0, next contention granted to requester 0.
REQ-038 clr_i re-pulsed in CLEAR cycle 4 -> busy_o still high exactly 8 cycles total.

Source files
------------

// File: rtl/iob_regfile_arb_pkg.sv
// Shared definitions for the two-requester register file with sequential clear.
//   state_t  : controller state encoding (IDLE, CLEAR)
//   NUM_REQ  : number of requesters sharing the file
package iob_regfile_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/iob_regfile_arb_if.sv
// Request/response bundle between the requesters and the register file.
//   req_valid_i / req_we_i   : per-requester valid and write enable
//   req_addr_i / req_wdata_i : per-requester address and write data (slice k = requester k)
//   req_ready_o              : per-requester accept (one-hot or zero)
//   rsp_valid_o / rsp_data_o : per-requester read response strobe and data
// master = requester side, slave = register file side.
interface iob_regfile_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    import iob_regfile_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [NUM_REQ*DATA_W-1:0] rsp_data_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );

endinterface

// File: rtl/iob_rr_arb2.sv
// Two-way round-robin arbiter with last-grant register.
//   clk, arst (async high), rst (sync high)
//   en    : arbitration allowed this cycle (grant forced to zero otherwise)
//   valid : per-requester request
//   grant : combinational one-hot-or-zero grant
module iob_rr_arb2
    import iob_regfile_arb_pkg::*;
(
    input  logic               clk,
    input  logic               arst,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant
);

    // Index of the requester that won the most recent transfer. Resets to 1
    // so requester 0 wins the first contention.
    logic last_q;

    always_comb begin
        grant = '0;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    // grant is only ever raised for a valid requester, so any grant is a transfer.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_q <= 1'b1;
        end else if (rst) begin
            last_q <= 1'b1;
        end else if (|grant) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/iob_regfile_arb.sv
// Register file shared by two requesters through a round-robin arbiter, with a
// sequential clear that walks every entry back to RST_VAL one per cycle.
//   clk_i  : clock          arst_i : async reset (high)   rst_i : sync reset (high)
//   clr_i  : start clear    busy_o : clear in progress
//   bus    : request/response bundle (slave side)
module iob_regfile_arb
    import iob_regfile_arb_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 3,
    parameter int unsigned RST_VAL = 0
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            rst_i,
    input  logic            clr_i,
    output logic            busy_o,
    iob_regfile_arb_if.slave bus
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(RST_VAL);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t                          state;
    logic [ADDR_W-1:0]               clr_cnt;
    logic [DATA_W-1:0]               mem [DEPTH];
    logic                            busy_q;
    logic [NUM_REQ-1:0]              rsp_valid_q;
    logic [NUM_REQ-1:0][DATA_W-1:0]  rsp_data_q;

    logic [NUM_REQ-1:0] grant;
    logic               arb_en;
    logic               xfer;
    logic               sel;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Clear request and sync reset both pre-empt arbitration in the same cycle.
    assign arb_en = (state == ST_IDLE) && !clr_i && !rst_i;

    iob_rr_arb2 u_arb (
        .clk   (clk_i),
        .arst  (arst_i),
        .rst   (rst_i),
        .en    (arb_en),
        .valid (bus.req_valid_i),
        .grant (grant)
    );

    assign xfer      = |grant;
    assign sel       = grant[1];
    assign sel_we    = sel ? bus.req_we_i[1] : bus.req_we_i[0];
    assign sel_addr  = sel ? bus.req_addr_i[2*ADDR_W-1:ADDR_W] : bus.req_addr_i[ADDR_W-1:0];
    assign sel_wdata = sel ? bus.req_wdata_i[2*DATA_W-1:DATA_W] : bus.req_wdata_i[DATA_W-1:0];

    assign bus.req_ready_o = grant;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign busy_o          = busy_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_WORD;
        end else if (rst_i) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_WORD;
        end else begin
            // Response strobe is a single-cycle pulse; data holds between pulses.
            rsp_valid_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (clr_i) begin
                        state   <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clr_cnt <= '0;
                    end else if (xfer) begin
                        if (sel_we) begin
                            mem[sel_addr] <= sel_wdata;
                        end else begin
                            rsp_valid_q[sel] <= 1'b1;
                            rsp_data_q[sel]  <= mem[sel_addr];
                        end
                    end
                end
                ST_CLEAR: begin
                    // clr_i is not looked at here, so a repeat pulse cannot extend the walk.
                    mem[clr_cnt] <= RST_WORD;
                    clr_cnt      <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_regfile_arb.sv
// Directed self-checking bench for iob_regfile_arb: a table of single-cycle
// vectors for arbitration/read/write, then hand sequences for clear and resets.
module tb_iob_regfile_arb;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;
    logic rst_i  = 1'b0;
    logic clr_i  = 1'b0;
    logic busy_o;

    int checks   = 0;
    int failures = 0;

    iob_regfile_arb_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    iob_regfile_arb #(.DATA_W(32), .ADDR_W(3), .RST_VAL(0)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .busy_o (busy_o),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [2:0]  a0;
        logic [2:0]  a1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [1:0]  e_ready;
        logic [1:0]  e_rv;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [31:0] w0, input logic [31:0] w1);
        bus.req_valid_i = v;
        bus.req_we_i    = we;
        bus.req_addr_i  = {a1, a0};
        bus.req_wdata_i = {w1, w0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic wr0(input logic [2:0] a, input logic [31:0] d);
        drive(2'b01, 2'b01, a, 3'd0, d, 32'h0);
        tick();
        idle();
    endtask

    task automatic rd0(input logic [2:0] a, input logic [31:0] exp, input string nm);
        drive(2'b01, 2'b00, a, 3'd0, 32'h0, 32'h0);
        #1;
        chk({nm, "_ready"}, 64'(bus.req_ready_o), 64'(2'b01));
        tick();
        chk({nm, "_rv"}, 64'(bus.rsp_valid_o), 64'(2'b01));
        chk({nm, "_data"}, 64'(bus.rsp_data_o[31:0]), 64'(exp));
        idle();
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) wr0(3'(i), 32'h11 * i);
    endtask

    // Counts busy cycles after a clr pulse; optionally re-pulses clr or raises
    // rst_i in a given busy cycle (0 = never).
    task automatic run_clear(input int clr_at, input int rst_at, output int cnt);
        cnt = 0;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) break;
            cnt++;
            clr_i = (cnt == clr_at);
            rst_i = (cnt == rst_at);
            tick();
            clr_i = 1'b0;
            rst_i = 1'b0;
        end
    endtask

    initial begin
        int n;
        //            valid  we     a0    a1    w0            w1        ready  rv     d0            d1
        vecs[0]  = '{2'b01, 2'b00, 3'd5, 3'd0, 32'h0,        32'h0,    2'b01, 2'b01, 32'h0,        32'h0};
        vecs[1]  = '{2'b01, 2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0,    2'b01, 2'b00, 32'h0,        32'h0};
        vecs[2]  = '{2'b10, 2'b00, 3'd0, 3'd3, 32'h0,        32'h0,    2'b10, 2'b10, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{2'b11, 2'b00, 3'd3, 3'd5, 32'h0,        32'h0,    2'b01, 2'b01, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4]  = '{2'b11, 2'b00, 3'd3, 3'd5, 32'h0,        32'h0,    2'b10, 2'b10, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{2'b11, 2'b00, 3'd3, 3'd5, 32'h0,        32'h0,    2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{2'b11, 2'b00, 3'd3, 3'd5, 32'h0,        32'h0,    2'b10, 2'b10, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{2'b00, 2'b00, 3'd3, 3'd5, 32'h0,        32'h0,    2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[8]  = '{2'b11, 2'b11, 3'd1, 3'd2, 32'h11,       32'h22,   2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[9]  = '{2'b11, 2'b11, 3'd1, 3'd2, 32'h11,       32'h22,   2'b10, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[10] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'h0,        32'h0,    2'b01, 2'b01, 32'h11,       32'h0};
        vecs[11] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'h0,        32'h0,    2'b10, 2'b10, 32'h11,       32'h22};

        idle();
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_busy", 64'(busy_o), 64'(1'b0));
        chk("rst_rv", 64'(bus.rsp_valid_o), 64'(2'b00));
        chk("rst_data", 64'(bus.rsp_data_o), 64'h0);

        // Table: reset read, write/read-back, alternating contention, holds.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(bus.req_ready_o), 64'(vecs[i].e_ready));
            tick();
            chk($sformatf("v%0d_rv", i), 64'(bus.rsp_valid_o), 64'(vecs[i].e_rv));
            chk($sformatf("v%0d_d0", i), 64'(bus.rsp_data_o[31:0]), 64'(vecs[i].e_d0));
            chk($sformatf("v%0d_d1", i), 64'(bus.rsp_data_o[63:32]), 64'(vecs[i].e_d1));
            chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(1'b0));
        end
        idle();

        // Clear with contention in the clr cycle; read just before clr still answers.
        fill();
        drive(2'b01, 2'b00, 3'd7, 3'd0, 32'h0, 32'h0);
        tick();
        drive(2'b11, 2'b00, 3'd6, 3'd6, 32'h0, 32'h0);
        clr_i = 1'b1;
        #1;
        chk("clr_ready", 64'(bus.req_ready_o), 64'(2'b00));
        chk("pre_clr_rv", 64'(bus.rsp_valid_o), 64'(2'b01));
        chk("pre_clr_data", 64'(bus.rsp_data_o[31:0]), 64'h77);
        tick();
        clr_i = 1'b0;
        chk("clr_no_rsp", 64'(bus.rsp_valid_o), 64'(2'b00));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) break;
            n++;
            #1;
            chk("clear_ready", 64'(bus.req_ready_o), 64'(2'b00));
            tick();
        end
        chk("clear_len", 64'(n), 64'd8);
        idle();
        for (int i = 0; i < 8; i++) rd0(3'(i), 32'h0, $sformatf("clr_rd%0d", i));

        // Repeat clr pulse in clear cycle 4 does not extend it.
        fill();
        run_clear(4, 0, n);
        chk("reclr_len", 64'(n), 64'd8);
        rd0(3'd5, 32'h0, "reclr_rd5");

        // Sync reset in clear cycle 3 aborts; last grant reloads to favour requester 0.
        fill();
        run_clear(0, 3, n);
        chk("rst_abort_len", 64'(n), 64'd3);
        chk("rst_abort_busy", 64'(busy_o), 64'(1'b0));
        chk("rst_abort_data", 64'(bus.rsp_data_o), 64'h0);
        drive(2'b11, 2'b00, 3'd4, 3'd4, 32'h0, 32'h0);
        #1;
        chk("rst_contend", 64'(bus.req_ready_o), 64'(2'b01));
        tick();
        idle();
        for (int i = 0; i < 8; i++) rd0(3'(i), 32'h0, $sformatf("rst_rd%0d", i));

        // Sync reset blocks any transfer in its cycle.
        drive(2'b01, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
        rst_i = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.req_ready_o), 64'(2'b00));
        tick();
        rst_i = 1'b0;
        chk("rst_no_rsp", 64'(bus.rsp_valid_o), 64'(2'b00));
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
